// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes and FSM state encodings for the MEM-stage exception controller.
package exc_ctrl_pkg;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } excState_t;

endpackage

// File: rtl/exc_ctrl_cp0_timer.sv
// Count/Compare match detector holding the latched timer interrupt until Compare is rewritten.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] count_i,
    input  logic [31:0] compare_i,
    input  logic        compare_we_i,
    output logic        timer_int_o
);

    logic r_timerInt;
    logic w_match;

    // A Compare of zero means the timer is disarmed, so it never matches.
    assign w_match = (compare_i != 32'h0) && (count_i == compare_i);

    // Software acknowledges by writing Compare; that write beats a simultaneous match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timerInt <= 1'b0;
        end else if (compare_we_i) begin
            r_timerInt <= 1'b0;
        end else if (w_match) begin
            r_timerInt <= 1'b1;
        end
    end

    assign timer_int_o = r_timerInt;

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception initiator: prioritises exceptions, drives CP0's exception port and
// issues a one-cycle flush with the redirect PC followed by a short drain window.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        syscall_i,
    input  logic        inv_instr_i,
    input  logic        ovf_i,
    input  logic        eret_i,
    input  logic [5:0]  int_i,
    input  logic        ie_i,
    input  logic [5:0]  im_i,
    input  logic [31:0] count_i,
    input  logic [31:0] compare_i,
    input  logic        compare_we_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_pc_o,
    output logic [5:0]  cp0_int_o,
    output logic        timer_int_o,
    output logic        exl_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    excState_t   r_state;
    excState_t   w_nextState;
    logic [2:0]  r_drainCnt;
    logic        r_flush;
    logic        r_exl;
    logic [31:0] r_newPc;
    logic        w_timerInt;
    logic [5:0]  w_cp0Int;
    logic        w_intPend;
    logic [31:0] w_exceptType;

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_i      (count_i),
        .compare_i    (compare_i),
        .compare_we_i (compare_we_i),
        .timer_int_o  (w_timerInt)
    );

    // The timer shares IP7 with external line 5, as on the classic MIPS32 core.
    assign w_cp0Int  = {w_timerInt | int_i[5], int_i[4:0]};
    assign w_intPend = ie_i & ~r_exl & (|(w_cp0Int & im_i));

    // Bubbles and the flush/drain window never raise an exception.
    always_comb begin
        w_exceptType = ZeroWord;
        if (r_state == IDLE && mem_valid_i) begin
            if (w_intPend)        w_exceptType = EXC_INT;
            else if (syscall_i)   w_exceptType = EXC_SYS;
            else if (inv_instr_i) w_exceptType = EXC_RI;
            else if (ovf_i)       w_exceptType = EXC_OV;
            else if (eret_i)      w_exceptType = EXC_ERET;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_exceptType != ZeroWord) w_nextState = FLUSH;
            FLUSH:   w_nextState = DRAIN;
            DRAIN:   if (r_drainCnt == 3'd0) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // ERET returns to EPC and leaves exception level; everything else enters it at the vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush    <= 1'b0;
            r_exl      <= 1'b0;
            r_newPc    <= ZeroWord;
            r_drainCnt <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_exceptType != ZeroWord) begin
                        r_flush <= 1'b1;
                        r_newPc <= (w_exceptType == EXC_ERET) ? epc_i : EXC_VECTOR;
                        r_exl   <= (w_exceptType != EXC_ERET);
                    end
                end
                FLUSH: begin
                    r_flush    <= 1'b0;
                    r_drainCnt <= DRAIN_LOAD;
                end
                DRAIN: begin
                    if (r_drainCnt != 3'd0) r_drainCnt <= r_drainCnt - 3'd1;
                end
                default: r_flush <= 1'b0;
            endcase
        end
    end

    assign excepttype_o = w_exceptType;
    assign current_pc_o = (w_exceptType != ZeroWord) ? mem_pc_i : ZeroWord;
    assign cp0_int_o    = w_cp0Int;
    assign timer_int_o  = w_timerInt;
    assign exl_o        = r_exl;
    assign flush_o      = r_flush;
    assign new_pc_o     = r_newPc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed scoreboard bench for exc_ctrl: stimulus pushes expected flush responses,
// an independent monitor pops them whenever the DUT pulses flush_o.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_pc_i = 32'h0;
    logic        syscall_i = 1'b0;
    logic        inv_instr_i = 1'b0;
    logic        ovf_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [5:0]  int_i = 6'h0;
    logic        ie_i = 1'b0;
    logic [5:0]  im_i = 6'h0;
    logic [31:0] count_i = 32'h0;
    logic [31:0] compare_i = 32'h0;
    logic        compare_we_i = 1'b0;
    logic [31:0] epc_i = 32'h0040_0010;
    logic [31:0] excepttype_o;
    logic [31:0] current_pc_o;
    logic [5:0]  cp0_int_o;
    logic        timer_int_o;
    logic        exl_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    typedef struct packed {
        logic [31:0] newPc;
        logic        exl;
    } flushExp_t;

    flushExp_t expQ[$];
    int        vectorCount = 0;
    int        missCount   = 0;

    localparam logic [31:0] VEC = 32'h0000_0040;
    localparam logic [31:0] EPC = 32'h0040_0010;

    exc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid_i  (mem_valid_i),
        .mem_pc_i     (mem_pc_i),
        .syscall_i    (syscall_i),
        .inv_instr_i  (inv_instr_i),
        .ovf_i        (ovf_i),
        .eret_i       (eret_i),
        .int_i        (int_i),
        .ie_i         (ie_i),
        .im_i         (im_i),
        .count_i      (count_i),
        .compare_i    (compare_i),
        .compare_we_i (compare_we_i),
        .epc_i        (epc_i),
        .excepttype_o (excepttype_o),
        .current_pc_o (current_pc_o),
        .cp0_int_o    (cp0_int_o),
        .timer_int_o  (timer_int_o),
        .exl_o        (exl_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every flush cycle must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #2;
        if (flush_o === 1'b1) begin
            if (expQ.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL unexpected_flush: got flush_o=1 new_pc=%h expected no flush at %0t", new_pc_o, $time);
            end else begin
                flushExp_t e;
                e = expQ.pop_front();
                checkOutput("flush_new_pc", new_pc_o, e.newPc);
                checkOutput("flush_exl", {31'h0, exl_o}, {31'h0, e.exl});
            end
        end
    end

    // Drives one MEM-stage instruction and checks the combinational exception port.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic s, input logic ri,
                                 input logic ov, input logic er, input logic [31:0] expCode,
                                 input logic [31:0] expNewPc, input logic expExl);
        @(negedge clk);
        mem_valid_i = v; mem_pc_i = pc; syscall_i = s; inv_instr_i = ri; ovf_i = ov; eret_i = er;
        #1;
        checkOutput("excepttype", excepttype_o, expCode);
        checkOutput("current_pc", current_pc_o, (expCode != 32'h0) ? pc : 32'h0);
        if (expCode != 32'h0) expQ.push_back('{newPc: expNewPc, exl: expExl});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_valid_i = 1'b0; syscall_i = 1'b0; inv_instr_i = 1'b0; ovf_i = 1'b0; eret_i = 1'b0;
        end
    endtask

    task automatic applyTimer(input logic [31:0] cnt, input logic [31:0] cmp, input logic we, input logic expTimer);
        @(negedge clk);
        count_i = cnt; compare_i = cmp; compare_we_i = we;
        @(posedge clk);
        #1;
        checkOutput("timer_int", {31'h0, timer_int_o}, {31'h0, expTimer});
        checkOutput("cp0_int_5", {31'h0, cp0_int_o[5]}, {31'h0, expTimer | int_i[5]});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_flush", {31'h0, flush_o}, 32'h0);
        checkOutput("reset_exl", {31'h0, exl_o}, 32'h0);
        checkOutput("reset_timer", {31'h0, timer_int_o}, 32'h0);
        checkOutput("reset_new_pc", new_pc_o, 32'h0);
        checkOutput("reset_excepttype", excepttype_o, 32'h0);

        // Syscall, then the same syscall held through FLUSH and both DRAIN cycles is ignored.
        applyStimulus(1, 32'h0040_0010, 1, 0, 0, 0, 32'h8, VEC, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 32'h0040_0014, 1, 0, 0, 0, 32'h0, VEC, 1'b1);
        applyStimulus(1, 32'h0040_0018, 0, 0, 0, 1, 32'he, EPC, 1'b0);
        idleCycles(4);

        // Interrupt line present but globally disabled: reserved instruction wins over overflow.
        int_i = 6'b000001; im_i = 6'b000001; ie_i = 1'b0;
        applyStimulus(1, 32'h0040_0100, 0, 1, 1, 0, 32'ha, VEC, 1'b1);
        idleCycles(4);
        applyStimulus(1, 32'h0040_0104, 0, 0, 0, 1, 32'he, EPC, 1'b0);
        idleCycles(4);
        // ERET with EXL already clear is still taken.
        applyStimulus(1, 32'h0040_0108, 0, 0, 0, 1, 32'he, EPC, 1'b0);
        idleCycles(4);

        // Pending interrupt beats instruction exceptions.
        ie_i = 1'b1;
        applyStimulus(1, 32'h0040_0200, 0, 1, 1, 0, 32'h1, VEC, 1'b1);
        idleCycles(4);
        // With EXL set the interrupt is masked but flags are still taken.
        applyStimulus(1, 32'h0040_0204, 0, 1, 0, 0, 32'ha, VEC, 1'b1);
        idleCycles(4);
        applyStimulus(1, 32'h0040_0208, 0, 0, 0, 0, 32'h0, VEC, 1'b1);
        applyStimulus(1, 32'h0040_020c, 0, 0, 0, 1, 32'he, EPC, 1'b0);
        idleCycles(4);

        // Bubbles hold off a pending interrupt until a real instruction arrives.
        applyStimulus(0, 32'h0040_0300, 0, 0, 0, 0, 32'h0, VEC, 1'b1);
        applyStimulus(0, 32'h0040_0304, 1, 0, 0, 0, 32'h0, VEC, 1'b1);
        applyStimulus(1, 32'h0040_0308, 0, 0, 0, 0, 32'h1, VEC, 1'b1);
        idleCycles(4);
        int_i = 6'h0;
        applyStimulus(1, 32'h0040_030c, 0, 0, 0, 1, 32'he, EPC, 1'b0);
        idleCycles(4);

        // Timer: match sets the latch, Compare write clears it, zero Compare and clear-vs-set.
        im_i = 6'b100000;
        applyTimer(32'd99, 32'd100, 1'b0, 1'b0);
        applyTimer(32'd100, 32'd100, 1'b0, 1'b1);
        applyStimulus(1, 32'h0040_0400, 0, 0, 0, 0, 32'h1, VEC, 1'b1);
        idleCycles(4);
        applyTimer(32'd101, 32'd100, 1'b1, 1'b0);
        applyTimer(32'd0, 32'd0, 1'b0, 1'b0);
        applyTimer(32'd5, 32'd5, 1'b1, 1'b0);
        applyTimer(32'd0, 32'd0, 1'b0, 1'b0);

        // Reset landing in the FLUSH cycle clears flush, EXL and the timer latch.
        applyTimer(32'd100, 32'd100, 1'b0, 1'b1);
        ie_i = 1'b0;
        applyStimulus(1, 32'h0040_0500, 1, 0, 0, 0, 32'h8, VEC, 1'b1);
        @(negedge clk);
        mem_valid_i = 1'b0; syscall_i = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_flush", {31'h0, flush_o}, 32'h0);
        checkOutput("rst_exl", {31'h0, exl_o}, 32'h0);
        checkOutput("rst_timer", {31'h0, timer_int_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0; count_i = 32'h0; compare_i = 32'h0;
        applyStimulus(1, 32'h0040_0600, 1, 0, 0, 0, 32'h8, VEC, 1'b1);
        idleCycles(6);

        vectorCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL missing_flush: got %0d flushes outstanding expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt initiator for the MIPS pipeline; it drives the CP0 exception port (excepttype, current_pc) that CP0 consumes.
- Sits at the MEM stage. Collects per-instruction exception flags, the external and timer interrupts, and the CP0 Count/Compare/Cause/EPC state.
- Picks one exception per instruction by priority, then issues a one-cycle pipeline flush with the redirect PC (exception vector or EPC on ERET).
- Owns the EXL flag, the timer-interrupt latch and a post-flush drain window.

Parameters:
- EXC_VECTOR, 32'h00000040, redirect PC for every exception except ERET.
- DRAIN_CYCLES, 2, cycles after a flush during which new exceptions are ignored (range 1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid_i  in  1  a real instruction occupies MEM (not a bubble)
- mem_pc_i  in  32  PC of the MEM instruction
- syscall_i  in  1  SYSCALL in MEM
- inv_instr_i  in  1  reserved/invalid instruction in MEM
- ovf_i  in  1  arithmetic overflow in MEM
- eret_i  in  1  ERET in MEM
- int_i  in  6  external hardware interrupts (IP[7:2])
- ie_i  in  1  global interrupt enable
- im_i  in  6  interrupt mask for IP[7:2]
- count_i  in  32  CP0 Count
- compare_i  in  32  CP0 Compare
- compare_we_i  in  1  CP0 write to Compare this cycle
- epc_i  in  32  CP0 EPC
- excepttype_o  out  32  exception code to CP0 (combinational)
- current_pc_o  out  32  PC to save into EPC (combinational)
- cp0_int_o  out  6  interrupt lines to CP0 Cause[15:10], equal to {timer_int_o | int_i[5], int_i[4:0]}
- timer_int_o  out  1  latched timer interrupt
- exl_o  out  1  exception level flag
- flush_o  out  1  registered one-cycle flush pulse
- new_pc_o  out  32  redirect PC, valid while flush_o=1

Behaviour:
- Reset values: timer_int_o=0, exl_o=0, flush_o=0, new_pc_o=0, FSM state IDLE, drain counter 0.
- Timer latch:
  - Sets to 1 on a clock edge where compare_i != 0 and count_i == compare_i.
  - Clears when compare_we_i=1. A clear and a set in the same cycle: clear wins.
- Interrupt pending: int_pend = ie_i & ~exl_o & |(cp0_int_o & im_i).
- Excepttype, combinational. It is non-zero only when state==IDLE and mem_valid_i=1. Priority, highest first:
  - int_pend -> 32'h1
  - syscall -> 32'h8
  - inv_instr -> 32'ha
  - ovf -> 32'hc
  - eret -> 32'he
  - otherwise 32'h0
- current_pc_o = mem_pc_i whenever excepttype_o != 0, else 0.
- FSM states:
  - IDLE -> FLUSH when excepttype_o != 0. On that edge, register flush_o=1 and new_pc_o, where new_pc_o = epc_i if the code is 32'he, else EXC_VECTOR. EXL is set to 1 for any code other than 32'he and cleared to 0 for 32'he.
  - FLUSH (1 cycle, flush_o=1) -> DRAIN; flush_o returns to 0 and the counter loads DRAIN_CYCLES-1.
  - DRAIN: the counter decrements each cycle; excepttype_o is forced to 0; -> IDLE when the counter reaches 0.
- Latency: exception seen in MEM at cycle N -> flush_o high in cycle N+1 for exactly 1 cycle.
- Exception flags while exl_o=1 are still taken, but interrupts are masked. EPC is overwritten by CP0.
- ERET with exl_o=0 is still taken (redirect to epc_i, EXL stays 0).
- A bubble (mem_valid_i=0) never generates an exception, even if interrupts are pending; the interrupt waits for the next valid instruction.
- Reset mid-FLUSH or mid-DRAIN: returns to IDLE next edge and flush_o drops.

Decomposition:
- Shared package/defines:
  - EXC_INT, EXC_SYS, EXC_RI, EXC_OV, EXC_ERET codes
  - ZeroWord
  - FSM state encodings (IDLE/FLUSH/DRAIN)
- Sub-module cp0_timer: the Count/Compare match and timer-latch logic, instantiated once. The FSM and priority encoder stay in exc_ctrl.

Test Plan:
- Syscall: mem_valid_i=1, mem_pc_i=32'h00400010, syscall_i=1 -> excepttype_o=32'h8 and current_pc_o=32'h00400010 that cycle; flush_o=1 next cycle with new_pc_o=32'h40; exl_o=1; a syscall asserted during the 2 DRAIN cycles is ignored.
- Timer: compare_i=100, count_i steps 99->100 -> timer_int_o=1, cp0_int_o[5]=1; with ie_i=1, im_i=6'b100000, exl_o=0 -> excepttype_o=32'h1. Then compare_we_i=1 -> timer_int_o=0. With compare_i=0 and count_i=0 -> no set.
- ERET: after exception entry (exl_o=1), epc_i=32'h00400010, eret_i=1 -> excepttype_o=32'he, new_pc_o=32'h00400010, exl_o=0.
- Priority: int pending + inv_instr_i + ovf_i in the same cycle -> 32'h1. With ie_i=0 -> 32'ha. With exl_o=1 and an interrupt pending -> no interrupt taken.
- Bubble/reset: pending interrupt with mem_valid_i=0 -> excepttype_o=0 until mem_valid_i=1. rst asserted during FLUSH -> flush_o=0, exl_o=0, timer_int_o=0 next edge.
